// File: rtl/tour_cmd_if.sv
// Command handshake between the tour sequencer and cmd_proc.
// The master presents cmd/cmd_rdy/resp; the slave answers with clr_cmd_rdy/send_resp.
interface tour_cmd_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport master (
        output cmd,
        output cmd_rdy,
        output resp,
        input  clr_cmd_rdy,
        input  send_resp
    );

    modport slave (
        input  cmd,
        input  cmd_rdy,
        input  resp,
        output clr_cmd_rdy,
        output send_resp
    );
endinterface

// File: rtl/tour_cmd.sv
// Command mux and knight-tour playback sequencer feeding cmd_proc.
// UART passthrough when idle; each stored move expands to a vertical and a horizontal command.
module tour_cmd (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_tour,
    input  logic [7:0]    move,
    output logic [4:0]    mv_indx,
    input  logic [15:0]   cmd_UART,
    input  logic          cmd_rdy_UART,
    tour_cmd_if.master    proc
);

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLD_V,
        HORZ,
        HOLD_H
    } state_t;

    localparam logic [4:0]  LAST_MOVE = 5'd23;
    localparam logic [7:0]  RESP_DONE = 8'hA5;
    localparam logic [7:0]  RESP_BUSY = 8'h5A;

    state_t      state;
    state_t      next;
    logic        last;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;

    assign last = (mv_indx == LAST_MOVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mv_indx <= '0;
        end else begin
            state <= next;
            if (start_tour)
                mv_indx <= '0;
            else if (state == HOLD_H && proc.send_resp && !last)
                mv_indx <= mv_indx + 5'd1;
        end
    end

    always_comb begin
        next = state;
        if (start_tour) begin
            next = VERT;
        end else begin
            unique case (state)
                IDLE:    next = IDLE;
                VERT:    if (proc.clr_cmd_rdy) next = HOLD_V;
                HOLD_V:  if (proc.send_resp) next = HORZ;
                HORZ:    if (proc.clr_cmd_rdy) next = HOLD_H;
                HOLD_H:  if (proc.send_resp) next = last ? IDLE : VERT;
                default: next = IDLE;
            endcase
        end
    end

    // Heading 0x00 north, 0x7F south, 0xBF east, 0x3F west; low nibble is square count.
    always_comb begin
        vert_cmd = 16'h0000;
        horz_cmd = 16'h0000;
        case (move)
            8'h01: begin vert_cmd = 16'h4002; horz_cmd = 16'h5BF1; end
            8'h02: begin vert_cmd = 16'h4002; horz_cmd = 16'h53F1; end
            8'h04: begin vert_cmd = 16'h4001; horz_cmd = 16'h53F2; end
            8'h08: begin vert_cmd = 16'h47F1; horz_cmd = 16'h53F2; end
            8'h10: begin vert_cmd = 16'h47F2; horz_cmd = 16'h53F1; end
            8'h20: begin vert_cmd = 16'h47F2; horz_cmd = 16'h5BF1; end
            8'h40: begin vert_cmd = 16'h47F1; horz_cmd = 16'h5BF2; end
            8'h80: begin vert_cmd = 16'h4001; horz_cmd = 16'h5BF2; end
            default: begin vert_cmd = 16'h0000; horz_cmd = 16'h0000; end
        endcase
    end

    always_comb begin
        proc.cmd     = cmd_UART;
        proc.cmd_rdy = cmd_rdy_UART;
        proc.resp    = RESP_BUSY;
        unique case (state)
            IDLE: begin
                proc.cmd     = cmd_UART;
                proc.cmd_rdy = cmd_rdy_UART;
                proc.resp    = RESP_DONE;
            end
            VERT: begin
                proc.cmd     = vert_cmd;
                proc.cmd_rdy = 1'b1;
            end
            HOLD_V: begin
                proc.cmd     = vert_cmd;
                proc.cmd_rdy = 1'b0;
            end
            HORZ: begin
                proc.cmd     = horz_cmd;
                proc.cmd_rdy = 1'b1;
            end
            HOLD_H: begin
                proc.cmd     = horz_cmd;
                proc.cmd_rdy = 1'b0;
                proc.resp    = last ? RESP_DONE : RESP_BUSY;
            end
            default: begin
                proc.cmd     = cmd_UART;
                proc.cmd_rdy = cmd_rdy_UART;
            end
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: a cmd_proc model serves commands
// and compares them against a queue of expected commands.
module tb_tour_cmd;

    logic        clk;
    logic        rst;
    logic        start_tour;
    logic [7:0]  move;
    logic [7:0]  move_drv;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    bit          tour_mode;
    logic [7:0]  tour_moves [0:31];

    int checks;
    int fails;

    logic [15:0] exp_q [$];

    tour_cmd_if bus();

    tour_cmd dut (
        .clk          (clk),
        .rst          (rst),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .proc         (bus.master)
    );

    // Solver storage lookup: zero-cycle read at the index the DUT requests.
    assign move = tour_mode ? tour_moves[mv_indx] : move_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_vert(input logic [7:0] m);
        logic [15:0] vt [0:7];
        vt = '{16'h4002, 16'h4002, 16'h4001, 16'h47F1,
               16'h47F2, 16'h47F2, 16'h47F1, 16'h4001};
        if ($countones(m) != 1) return 16'h0000;
        for (int b = 0; b < 8; b++)
            if (m[b]) return vt[b];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] ref_horz(input logic [7:0] m);
        logic [15:0] ht [0:7];
        ht = '{16'h5BF1, 16'h53F1, 16'h53F2, 16'h53F2,
               16'h53F1, 16'h5BF1, 16'h5BF2, 16'h5BF2};
        if ($countones(m) != 1) return 16'h0000;
        for (int b = 0; b < 8; b++)
            if (m[b]) return ht[b];
        return 16'h0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        #1;
    endtask

    // cmd_proc model: wait for cmd_rdy, check, accept, optionally respond.
    task automatic serve(input string tag, input logic [7:0] hold_resp,
                         input bit do_resp);
        logic [15:0] exp;
        int n;
        n = 0;
        while (bus.cmd_rdy !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        checks++;
        if (n >= 20) begin
            fails++;
            $display("FAIL %s_timeout cmd_rdy=%b required 1", tag, bus.cmd_rdy);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s_queue unexpected cmd %h", tag, bus.cmd);
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (bus.cmd !== exp) begin
            fails++;
            $display("FAIL %s_cmd got %h required %h", tag, bus.cmd, exp);
        end
        checks++;
        if (bus.resp !== 8'h5A) begin
            fails++;
            $display("FAIL %s_resp got %h required 5a", tag, bus.resp);
        end
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        #1;
        checks++;
        if (bus.cmd_rdy !== 1'b0) begin
            fails++;
            $display("FAIL %s_rdy_drop got %b required 0", tag, bus.cmd_rdy);
        end
        checks++;
        if (bus.cmd !== exp) begin
            fails++;
            $display("FAIL %s_cmd_hold got %h required %h", tag, bus.cmd, exp);
        end
        checks++;
        if (bus.resp !== hold_resp) begin
            fails++;
            $display("FAIL %s_hold_resp got %h required %h", tag, bus.resp, hold_resp);
        end
        if (do_resp) begin
            bus.send_resp = 1'b1;
            tick();
            bus.send_resp = 1'b0;
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (mv_indx !== 5'd0) begin
            fails++;
            $display("FAIL reset_indx got %0d required 0", mv_indx);
        end
        checks++;
        if (bus.cmd !== cmd_UART || bus.cmd_rdy !== cmd_rdy_UART) begin
            fails++;
            $display("FAIL reset_pass got %h/%b required %h/%b",
                     bus.cmd, bus.cmd_rdy, cmd_UART, cmd_rdy_UART);
        end
        checks++;
        if (bus.resp !== 8'hA5) begin
            fails++;
            $display("FAIL reset_resp got %h required a5", bus.resp);
        end
    endtask

    task automatic test_passthrough();
        cmd_UART     = 16'h1234;
        cmd_rdy_UART = 1'b1;
        #1;
        checks++;
        if (bus.cmd !== 16'h1234 || bus.cmd_rdy !== 1'b1 || bus.resp !== 8'hA5) begin
            fails++;
            $display("FAIL pass_1234 got %h/%b/%h required 1234/1/a5",
                     bus.cmd, bus.cmd_rdy, bus.resp);
        end
        bus.clr_cmd_rdy = 1'b1;
        bus.send_resp   = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        cmd_UART        = 16'hC3A0;
        cmd_rdy_UART    = 1'b0;
        #1;
        checks++;
        if (bus.cmd !== 16'hC3A0 || bus.cmd_rdy !== 1'b0 || bus.resp !== 8'hA5) begin
            fails++;
            $display("FAIL pass_idle_ignore got %h/%b/%h required c3a0/0/a5",
                     bus.cmd, bus.cmd_rdy, bus.resp);
        end
    endtask

    task automatic test_single_moves();
        logic [7:0] m;
        tour_mode = 1'b0;
        for (int b = 0; b < 8; b++) begin
            m = 8'h01 << b;
            move_drv = m;
            exp_q.delete();
            exp_q.push_back(ref_vert(m));
            exp_q.push_back(ref_horz(m));
            kick();
            serve($sformatf("mv%0d_v", b), 8'h5A, 1'b1);
            serve($sformatf("mv%0d_h", b), 8'h5A, 1'b1);
            checks++;
            if (mv_indx !== 5'd1) begin
                fails++;
                $display("FAIL mv%0d_indx got %0d required 1", b, mv_indx);
            end
        end
    endtask

    task automatic test_bad_move();
        logic [7:0] bad [0:1];
        bad = '{8'h00, 8'h03};
        tour_mode = 1'b0;
        for (int k = 0; k < 2; k++) begin
            move_drv = bad[k];
            exp_q.delete();
            exp_q.push_back(16'h0000);
            exp_q.push_back(16'h0000);
            kick();
            serve($sformatf("bad%0d_v", k), 8'h5A, 1'b1);
            serve($sformatf("bad%0d_h", k), 8'h5A, 1'b1);
        end
    endtask

    task automatic test_full_tour();
        for (int i = 0; i < 32; i++)
            tour_moves[i] = 8'h01 << $urandom_range(0, 7);
        tour_mode    = 1'b1;
        cmd_rdy_UART = 1'b0;
        exp_q.delete();
        kick();
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (mv_indx !== 5'(i)) begin
                fails++;
                $display("FAIL tour_indx got %0d required %0d", mv_indx, i);
            end
            exp_q.push_back(ref_vert(tour_moves[i]));
            exp_q.push_back(ref_horz(tour_moves[i]));
            serve($sformatf("tour%0d_v", i), 8'h5A, 1'b1);
            serve($sformatf("tour%0d_h", i), (i == 23) ? 8'hA5 : 8'h5A, 1'b1);
        end
        cmd_UART     = 16'hBEEF;
        cmd_rdy_UART = 1'b1;
        #1;
        checks++;
        if (bus.cmd !== 16'hBEEF || bus.cmd_rdy !== 1'b1 || bus.resp !== 8'hA5) begin
            fails++;
            $display("FAIL tour_end_pass got %h/%b/%h required beef/1/a5",
                     bus.cmd, bus.cmd_rdy, bus.resp);
        end
        checks++;
        if (mv_indx !== 5'd23) begin
            fails++;
            $display("FAIL tour_end_indx got %0d required 23", mv_indx);
        end
        tick();
        checks++;
        if (mv_indx !== 5'd23 || bus.resp !== 8'hA5) begin
            fails++;
            $display("FAIL tour_idle_hold got %0d/%h required 23/a5", mv_indx, bus.resp);
        end
        cmd_rdy_UART = 1'b0;
        #1;
    endtask

    task automatic test_restart_hold_h();
        tour_mode = 1'b1;
        exp_q.delete();
        kick();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ref_vert(tour_moves[i]));
            exp_q.push_back(ref_horz(tour_moves[i]));
            serve($sformatf("rs%0d_v", i), 8'h5A, 1'b1);
            serve($sformatf("rs%0d_h", i), 8'h5A, (i != 5));
        end
        checks++;
        if (mv_indx !== 5'd5) begin
            fails++;
            $display("FAIL restart_pre_indx got %0d required 5", mv_indx);
        end
        start_tour    = 1'b1;
        bus.send_resp = 1'b1;
        tick();
        start_tour    = 1'b0;
        bus.send_resp = 1'b0;
        #1;
        checks++;
        if (mv_indx !== 5'd0 || bus.cmd_rdy !== 1'b1 ||
            bus.cmd !== ref_vert(tour_moves[0])) begin
            fails++;
            $display("FAIL restart_vert got %0d/%b/%h required 0/1/%h",
                     mv_indx, bus.cmd_rdy, bus.cmd, ref_vert(tour_moves[0]));
        end
    endtask

    task automatic test_reset_mid();
        tour_mode = 1'b1;
        exp_q.delete();
        kick();
        exp_q.push_back(ref_vert(tour_moves[0]));
        exp_q.push_back(ref_horz(tour_moves[0]));
        exp_q.push_back(ref_vert(tour_moves[1]));
        serve("rm0_v", 8'h5A, 1'b1);
        serve("rm0_h", 8'h5A, 1'b1);
        serve("rm1_v", 8'h5A, 1'b1);
        checks++;
        if (bus.cmd_rdy !== 1'b1 || bus.cmd !== ref_horz(tour_moves[1]) ||
            mv_indx !== 5'd1) begin
            fails++;
            $display("FAIL rm_horz got %b/%h/%0d required 1/%h/1",
                     bus.cmd_rdy, bus.cmd, mv_indx, ref_horz(tour_moves[1]));
        end
        cmd_UART     = 16'h0F0F;
        cmd_rdy_UART = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (mv_indx !== 5'd0 || bus.cmd !== 16'h0F0F || bus.cmd_rdy !== 1'b0 ||
            bus.resp !== 8'hA5) begin
            fails++;
            $display("FAIL rm_reset got %0d/%h/%b/%h required 0/0f0f/0/a5",
                     mv_indx, bus.cmd, bus.cmd_rdy, bus.resp);
        end
    endtask

    initial begin
        checks          = 0;
        fails           = 0;
        rst             = 1'b1;
        start_tour      = 1'b0;
        move_drv        = 8'h00;
        tour_mode       = 1'b0;
        cmd_UART        = 16'h0000;
        cmd_rdy_UART    = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        for (int i = 0; i < 32; i++)
            tour_moves[i] = 8'h01;
        test_reset();
        test_passthrough();
        test_single_moves();
        test_bad_move();
        test_full_tour();
        test_restart_hold_h();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
# tour_cmd

Command multiplexer and tour-move sequencer for the Knight's Tour robot. It sits between the UART wrapper, the tour solver and cmd_proc. When idle, it passes UART commands straight through to cmd_proc. After a tour is solved, it replays the 24 stored knight moves, expanding each into a vertical move command followed by a horizontal move-with-fanfare command.

## Interface
- No parameters.
- clk  in  1  system clock (50 MHz); all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_tour  in  1  one-cycle pulse from the solver when a tour is ready; starts playback.
- move  in  8  one-hot encoded move read from solver storage at mv_indx.
- mv_indx  out  5  index of the move currently being played, 0..23.
- cmd_UART  in  16  command from the UART wrapper.
- cmd_rdy_UART  in  1  command-ready flag from the UART wrapper.
- cmd  out  16  multiplexed command to cmd_proc.
- cmd_rdy  out  1  command-ready flag to cmd_proc.
- clr_cmd_rdy  in  1  cmd_proc has accepted cmd.
- send_resp  in  1  cmd_proc has finished executing cmd.
- resp  out  8  response byte: 0xA5 (done) or 0x5A (tour in progress).

## Operation
- Command format: cmd[15:12] is the opcode, cmd[11:4] is the heading, cmd[3:0] is the number of squares.
  - Opcodes: 4 = move, 5 = move with fanfare.
  - Headings: north 0x00, west 0x3F, south 0x7F, east 0xBF.
- Each move produces a vertical command (opcode 4), then a horizontal command (opcode 5).

Vertical / horizontal command for each value of the one-hot move:
- bit0: 0x4002 / 0x5BF1 (up 2, right 1)
- bit1: 0x4002 / 0x53F1 (up 2, left 1)
- bit2: 0x4001 / 0x53F2 (up 1, left 2)
- bit3: 0x47F1 / 0x53F2 (down 1, left 2)
- bit4: 0x47F2 / 0x53F1 (down 2, left 1)
- bit5: 0x47F2 / 0x5BF1 (down 2, right 1)
- bit6: 0x47F1 / 0x5BF2 (down 1, right 2)
- bit7: 0x4001 / 0x5BF2 (up 1, right 2)
- move not one-hot (zero or multiple bits set): both commands are 0x0000.

FSM states:
- IDLE: UART mode.
  - cmd = cmd_UART, cmd_rdy = cmd_rdy_UART.
  - start_tour → VERT, mv_indx cleared to 0.
- VERT: cmd = vertical command of move, cmd_rdy = 1.
  - clr_cmd_rdy → HOLD_V.
- HOLD_V: cmd = vertical command, cmd_rdy = 0.
  - send_resp → HORZ.
- HORZ: cmd = horizontal command, cmd_rdy = 1.
  - clr_cmd_rdy → HOLD_H.
- HOLD_H: cmd = horizontal command, cmd_rdy = 0.
  - send_resp with mv_indx == 23 → IDLE.
  - send_resp otherwise → mv_indx + 1, then VERT.

Priority and boundary rules:
- start_tour has priority over every other input in every state: it clears mv_indx and forces VERT (restart mid-tour).
- mv_indx never exceeds 23; it holds its value in IDLE.
- clr_cmd_rdy in HOLD states and send_resp in VERT/HORZ are ignored.
- send_resp and clr_cmd_rdy are ignored for sequencing in IDLE.
- resp = 0xA5 in IDLE, or when in HOLD_H with mv_indx == 23; otherwise resp = 0x5A.
- cmd, cmd_rdy and resp are combinational functions of the state, mv_indx, move and the UART inputs.

## Timing
- Reset: state IDLE, mv_indx = 0, cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, resp = 0xA5.
- start_tour high at edge N: VERT from cycle N+1, so cmd_rdy = 1 and the vertical cmd appear one cycle later.
- move must be valid while the FSM is in VERT through HOLD_H; the solver presents it from mv_indx with zero-cycle lookup.
- clr_cmd_rdy at edge: cmd_rdy drops in the following cycle; cmd holds its value.
- send_resp at edge: the next command is presented in the following cycle.
- Minimum of 4 cycles per move.
- Reset mid-tour aborts playback and returns to IDLE.

## Test plan
- Reset, then drive cmd_UART = 0x1234 with cmd_rdy_UART = 1 → cmd = 0x1234, cmd_rdy = 1, resp = 0xA5.
- start_tour, move = 0x01, pulse clr_cmd_rdy → cmd = 0x4002 and cmd_rdy = 0; after send_resp → cmd = 0x5BF1, cmd_rdy = 1, resp = 0x5A.
- Cover all eight moves (0x01 … 0x80), restarting with start_tour before each; check each vertical/horizontal pair against the table above (e.g. 0x08 → 0x47F1 then 0x53F2).
- Full 24-move tour with a cmd_proc model → mv_indx steps 0..23; resp = 0xA5 after the final move; FSM returns to UART passthrough.
- start_tour asserted while in HOLD_H with mv_indx = 5 → mv_indx = 0, VERT next cycle.
- Reset asserted in HORZ → IDLE, mv_indx = 0, passthrough restored next cycle.
